// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and EX operand forwarding
// control for the 5-stage MIPS pipeline, with saturating stall/flush counters.
// The controller keeps its own shadow of the EX/MEM/WB control and register
// fields, so it needs nothing from the datapath except ex_branch_taken.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_RegWr,
    input  logic             id_MemRd,
    input  logic             id_branch,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dst,
    input  logic             ex_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // EX shadow
    logic             r_ex_valid;
    logic             r_ex_RegWr;
    logic             r_ex_MemRd;
    logic             r_ex_branch;
    logic [4:0]       r_ex_rs;
    logic [4:0]       r_ex_rt;
    logic [4:0]       r_ex_dst;
    // MEM / WB shadows
    logic             r_mem_RegWr;
    logic [4:0]       r_mem_dst;
    logic             r_wb_RegWr;
    logic [4:0]       r_wb_dst;
    // performance counters
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_load_use;
    logic             w_flush;
    logic             w_stall;

    // A lw in EX whose destination is read by the real instruction in ID.
    assign w_load_use = r_ex_MemRd && (r_ex_dst != 5'd0) && id_valid &&
                        ((r_ex_dst == id_rs) || (id_uses_rt && (r_ex_dst == id_rt)));
    assign w_flush    = r_ex_valid && r_ex_branch && ex_branch_taken;
    // The flush kills the consumer in ID, so a simultaneous stall is moot.
    assign w_stall    = w_load_use && !w_flush;

    // Pipeline enables: reset holds the front end, then flush, then stall.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Operand forwarding: the younger MEM result beats WB, $0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (r_mem_RegWr && (r_mem_dst != 5'd0) && (r_mem_dst == r_ex_rs))
                fwd_a = 2'b10;
            else if (r_wb_RegWr && (r_wb_dst != 5'd0) && (r_wb_dst == r_ex_rs))
                fwd_a = 2'b01;
            if (r_mem_RegWr && (r_mem_dst != 5'd0) && (r_mem_dst == r_ex_rt))
                fwd_b = 2'b10;
            else if (r_wb_RegWr && (r_wb_dst != 5'd0) && (r_wb_dst == r_ex_rt))
                fwd_b = 2'b01;
        end
    end

    // Shadow pipeline advance; EX takes a NOP whenever a bubble is inserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_RegWr  <= 1'b0;
            r_ex_MemRd  <= 1'b0;
            r_ex_branch <= 1'b0;
            r_ex_rs     <= 5'd0;
            r_ex_rt     <= 5'd0;
            r_ex_dst    <= 5'd0;
            r_mem_RegWr <= 1'b0;
            r_mem_dst   <= 5'd0;
            r_wb_RegWr  <= 1'b0;
            r_wb_dst    <= 5'd0;
        end else begin
            if (idex_bubble) begin
                r_ex_valid  <= 1'b0;
                r_ex_RegWr  <= 1'b0;
                r_ex_MemRd  <= 1'b0;
                r_ex_branch <= 1'b0;
                r_ex_rs     <= 5'd0;
                r_ex_rt     <= 5'd0;
                r_ex_dst    <= 5'd0;
            end else begin
                r_ex_valid  <= id_valid;
                r_ex_RegWr  <= id_RegWr;
                r_ex_MemRd  <= id_MemRd;
                r_ex_branch <= id_branch;
                r_ex_rs     <= id_rs;
                r_ex_rt     <= id_rt;
                r_ex_dst    <= id_dst;
            end
            r_mem_RegWr <= r_ex_RegWr;
            r_mem_dst   <= r_ex_dst;
            r_wb_RegWr  <= r_mem_RegWr;
            r_wb_dst    <= r_mem_dst;
        end
    end

    // Saturating event counters; reset discards any event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table through the
// main instance, plus a counter-saturation sequence on a CNT_W=2 instance.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (CNT_W = 16)
    logic        rst, id_valid, id_RegWr, id_MemRd, id_branch, id_uses_rt, ex_branch_taken;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegWr(id_RegWr),
        .id_MemRd(id_MemRd), .id_branch(id_branch), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // saturation instance (CNT_W = 2)
    logic        s_rst, s_valid, s_RegWr, s_MemRd, s_branch, s_uses_rt, s_taken;
    logic [4:0]  s_rs, s_rt, s_dst;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .id_valid(s_valid), .id_RegWr(s_RegWr),
        .id_MemRd(s_MemRd), .id_branch(s_branch), .id_uses_rt(s_uses_rt),
        .id_rs(s_rs), .id_rt(s_rt), .id_dst(s_dst),
        .ex_branch_taken(s_taken), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic       r;
        logic       v, rw, mr, br, ut;
        logic [4:0] rs, rt, dst;
        logic       tk;
        logic       pc, ifw, fl, bub;
        logic [1:0] fa, fb;
        int         sc, fc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r,
                                input logic v, input logic rw, input logic mr,
                                input logic br, input logic ut,
                                input int rs, input int rt, input int dst,
                                input logic tk,
                                input logic pc, input logic ifw, input logic fl,
                                input logic bub, input int fa, input int fb,
                                input int sc, input int fc);
        vec_t t;
        t.r = r; t.v = v; t.rw = rw; t.mr = mr; t.br = br; t.ut = ut;
        t.rs = 5'(rs); t.rt = 5'(rt); t.dst = 5'(dst); t.tk = tk;
        t.pc = pc; t.ifw = ifw; t.fl = fl; t.bub = bub;
        t.fa = 2'(fa); t.fb = 2'(fb); t.sc = sc; t.fc = fc;
        return t;
    endfunction

    task automatic s_drive(input logic r, input logic v, input logic rw, input logic mr,
                           input int rs, input int rt, input int dst);
        s_rst = r; s_valid = v; s_RegWr = rw; s_MemRd = mr; s_branch = 1'b0;
        s_uses_rt = v & ~mr; s_rs = 5'(rs); s_rt = 5'(rt); s_dst = 5'(dst);
        s_taken = 1'b0;
    endtask

    vec_t vecs[22];

    initial begin
        // Cycle sequence; each row: rst | ID fields | taken | expected outputs.
        //                 r  v  rw mr br ut rs  rt  dst tk  pc if fl bu fa fb sc fc
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0); // in reset
        vecs[1]  = mk(0, 1, 1, 1, 0, 0,  1,  8,  8, 0,  1, 1, 0, 0, 0, 0, 0, 0); // lw $8
        vecs[2]  = mk(0, 1, 1, 0, 0, 1,  8,  2,  9, 0,  0, 0, 0, 1, 0, 0, 0, 0); // add $9,$8,$2 stall
        vecs[3]  = mk(0, 1, 1, 0, 0, 1,  8,  2,  9, 0,  1, 1, 0, 0, 0, 0, 1, 0); // add proceeds
        vecs[4]  = mk(0, 1, 1, 0, 0, 1,  1,  2,  3, 0,  1, 1, 0, 0, 1, 0, 1, 0); // add in EX: fwd_a=01
        vecs[5]  = mk(0, 1, 1, 0, 0, 1,  4,  5,  3, 0,  1, 1, 0, 0, 0, 0, 1, 0); // sub $3
        vecs[6]  = mk(0, 1, 1, 0, 0, 1,  3,  3,  4, 0,  1, 1, 0, 0, 0, 0, 1, 0); // or $4,$3,$3
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 2, 2, 1, 0); // or in EX: MEM wins
        vecs[8]  = mk(0, 1, 1, 0, 0, 1,  1,  2,  0, 0,  1, 1, 0, 0, 0, 0, 1, 0); // add $0
        vecs[9]  = mk(0, 1, 1, 0, 0, 1,  0,  0,  5, 0,  1, 1, 0, 0, 0, 0, 1, 0); // or $5,$0,$0
        vecs[10] = mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 0, 0, 1, 0); // $0 never forwards
        vecs[11] = mk(0, 1, 0, 0, 1, 1,  1,  2,  0, 0,  1, 1, 0, 0, 0, 0, 1, 0); // beq
        vecs[12] = mk(0, 1, 1, 0, 0, 1,  1,  1,  6, 1,  1, 1, 1, 1, 0, 0, 1, 0); // taken: flush
        vecs[13] = mk(0, 1, 1, 0, 0, 1,  1,  2,  7, 1,  1, 1, 0, 0, 0, 0, 1, 1); // one cycle only
        vecs[14] = mk(0, 1, 0, 0, 1, 1,  1,  2,  0, 0,  1, 1, 0, 0, 0, 0, 1, 1); // bne
        vecs[15] = mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 0, 0, 1, 1); // not taken
        vecs[16] = mk(0, 1, 1, 1, 1, 0,  1, 10, 10, 0,  1, 1, 0, 0, 0, 0, 1, 1); // lw+branch
        vecs[17] = mk(0, 1, 1, 0, 0, 1, 10,  2, 11, 1,  1, 1, 1, 1, 0, 0, 1, 1); // flush beats stall
        vecs[18] = mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 0, 0, 1, 2); // stall_cnt unchanged
        vecs[19] = mk(0, 1, 1, 1, 0, 0,  1, 12, 12, 0,  1, 1, 0, 0, 0, 0, 1, 2); // lw $12
        vecs[20] = mk(1, 1, 1, 0, 0, 1, 12, 12, 13, 0,  0, 0, 1, 1, 0, 0, 1, 2); // rst during stall
        vecs[21] = mk(0, 1, 1, 0, 0, 1, 12, 12, 13, 0,  1, 1, 0, 0, 0, 0, 0, 0); // no stall resumes

        rst = 1'b1; id_valid = 0; id_RegWr = 0; id_MemRd = 0; id_branch = 0;
        id_uses_rt = 0; id_rs = 0; id_rt = 0; id_dst = 0; ex_branch_taken = 0;
        s_drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            #1;
            rst = vecs[i].r; id_valid = vecs[i].v; id_RegWr = vecs[i].rw;
            id_MemRd = vecs[i].mr; id_branch = vecs[i].br; id_uses_rt = vecs[i].ut;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_dst = vecs[i].dst;
            ex_branch_taken = vecs[i].tk;
            @(negedge clk);
            chk($sformatf("v%0d pc_we", i),       int'(pc_we),       int'(vecs[i].pc));
            chk($sformatf("v%0d ifid_we", i),     int'(ifid_we),     int'(vecs[i].ifw));
            chk($sformatf("v%0d ifid_flush", i),  int'(ifid_flush),  int'(vecs[i].fl));
            chk($sformatf("v%0d idex_bubble", i), int'(idex_bubble), int'(vecs[i].bub));
            chk($sformatf("v%0d fwd_a", i),       int'(fwd_a),       int'(vecs[i].fa));
            chk($sformatf("v%0d fwd_b", i),       int'(fwd_b),       int'(vecs[i].fb));
            chk($sformatf("v%0d stall_cnt", i),   int'(stall_cnt),   vecs[i].sc);
            chk($sformatf("v%0d flush_cnt", i),   int'(flush_cnt),   vecs[i].fc);
            @(posedge clk);
        end

        // Saturation: five lw / dependent-add pairs on the 2-bit counter.
        #1;
        s_drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat reset stall_cnt", int'(s_stall_cnt), 0);
        for (int p = 0; p < 5; p++) begin
            @(posedge clk); #1;
            s_drive(0, 1, 1, 1, 1, 8, 8);              // lw $8,0($1)
            @(negedge clk);
            chk($sformatf("sat p%0d lw pc_we", p), int'(s_pc_we), 1);
            @(posedge clk); #1;
            s_drive(0, 1, 1, 0, 8, 2, 9);              // add $9,$8,$2
            @(negedge clk);
            chk($sformatf("sat p%0d stall pc_we", p), int'(s_pc_we), 0);
            chk($sformatf("sat p%0d stall bubble", p), int'(s_idex_bubble), 1);
            @(posedge clk); #1;                        // add held in ID, proceeds
            @(negedge clk);
            chk($sformatf("sat p%0d stall_cnt", p), int'(s_stall_cnt), (p + 1 > 3) ? 3 : p + 1);
            chk($sformatf("sat p%0d fwd_a", p), int'(s_fwd_a), 0);
        end
        @(posedge clk); #1;
        s_drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat hold stall_cnt", int'(s_stall_cnt), 3);
        chk("sat flush_cnt", int'(s_flush_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Takes the decoded control bits of the instruction in ID, already produced by the main control decoder.
- Keeps a shadow copy of the per-stage control and destination fields for EX, MEM and WB.
- Produces the PC and IF/ID write enables, IF/ID flush, ID/EX bubble insertion, and the EX-stage ALU operand forwarding selects.
- Keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_RegWr  in  1  ID instruction writes the register file
- id_MemRd  in  1  ID instruction is lw
- id_branch  in  1  ID instruction is beq, bne or bgtz
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- id_rs  in  5  rs field of the ID instruction
- id_rt  in  5  rt field of the ID instruction
- id_dst  in  5  destination register after the RegDst mux
- ex_branch_taken  in  1  branch condition from EX; meaningful only when EX holds a branch
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  clear IF/ID to a NOP on the next edge
- idex_bubble  out  1  load a NOP (all control bits 0) into ID/EX on the next edge
- fwd_a  out  2  select for ALU operand A; 00 register file, 10 EX/MEM result, 01 MEM/WB result
- fwd_b  out  2  select for ALU operand B, same encoding as fwd_a
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating
- flush_cnt  out  CNT_W  number of taken-branch flushes, saturating

## Operation
**Shadow pipeline registers**
- EX: ex_valid, ex_RegWr, ex_MemRd, ex_branch, ex_rs, ex_rt, ex_dst.
- MEM: mem_RegWr, mem_dst.
- WB: wb_RegWr, wb_dst.
- Each edge: MEM takes EX's values, WB takes MEM's values.
- EX takes the ID inputs, or all zeros when idex_bubble is 1.

**Load-use hazard**
- Condition: `ex_MemRd & ex_dst!=0 & id_valid & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt))`.
- Response: pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt increments.

**Branch flush**
- Condition: `ex_valid & ex_branch & ex_branch_taken`.
- Response: pc_we=1 (the external mux selects the target), ifid_we=1, ifid_flush=1, idex_bubble=1, flush_cnt increments.

**Priority**
- Flush beats load-use. When both are true, the stall is dropped and stall_cnt does not increment.
- The wrong-path instruction in ID is killed, so no stall is needed.

**Forwarding (fwd_a uses ex_rs, fwd_b uses ex_rt)**
- 10 when `mem_RegWr & mem_dst!=0 & mem_dst==src`.
- Otherwise 01 when `wb_RegWr & wb_dst!=0 & wb_dst==src`.
- Otherwise 00.
- MEM wins over WB. Register $0 never forwards.

**Other rules**
- The register file is write-before-read, so there is no WB→ID forwarding.
- Counters saturate at all-ones. There is no wrap.
- When no hazard is present: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.

## Timing
- Hazard and forward outputs are combinational from shadow registers and ID inputs, with zero latency.
- Counters update on the edge that ends the qualifying cycle.
- A load-use stall lasts exactly one cycle: next cycle the lw is in MEM with a bubble in EX, and the consumer later gets the value via fwd=01.
- A taken branch costs 2 cycles (the IF and ID slots are discarded).
- While rst=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1. Forward selects are 00.
- At the reset edge: all shadow registers and both counters clear to 0.
- First cycle after rst deasserts: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, counters 0.
- Reset asserted during a stall wins. Nothing from the cancelled hazard survives: the stall does not resume and its stall_cnt increment is cancelled.
- A bubble or flush does not change mem/wb shadows until normal advance.

## Test plan
- **Load-use on rs:** `lw $8,0($1)` then `add $9,$8,$2`.
  - One cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1.
  - When the add reaches EX: fwd_a=01, fwd_b=00.
- **Forward priority:** `add $3,..` ; `sub $3,..` ; `or $4,$3,$3`.
  - When the or is in EX: fwd_a=fwd_b=10 (MEM beats WB).
  - With $0 as destination instead: fwd stays 00.
- **Taken branch:** `beq` with ex_branch_taken=1 in EX.
  - ifid_flush=1, idex_bubble=1, pc_we=1 for exactly one cycle; flush_cnt=1.
  - With ex_branch_taken=0: no flush.
- **Flush versus load-use:** lw in EX that is also treated as a branch, with a dependent instruction in ID.
  - ifid_flush=1, pc_we=1; stall_cnt unchanged.
- **Reset mid-stall:** assert rst during the load-use cycle.
  - pc_we=0, ifid_flush=1 while rst is high; all counters 0 afterwards.
  - First post-reset cycle: pc_we=1, fwd=00.
- **Counter saturation:** CNT_W=2, 5 back-to-back load-use pairs.
  - stall_cnt reaches 3 and holds at 3.
